// File: rtl/prog_freq_divider_if.sv
// Control and status bundle for prog_freq_divider. The master drives the
// divisor request and count enable; the slave (divider) returns its status.
interface prog_freq_divider_if #(
  parameter int WIDTH = 17
) ();

  // Request handshake: div_load is a one-cycle valid strobe with no ready.
  // The divider always accepts it on the edge where it is high; pending then
  // stays high until that request (or a later overwrite) is applied.
  logic             enable;
  logic [WIDTH-1:0] div_in;
  logic             mode_in;
  logic             div_load;

  logic             final_clk;
  logic             tick;
  logic             pending;
  logic             running;
  logic [WIDTH-1:0] count;

  modport master (
    output enable,
    output div_in,
    output mode_in,
    output div_load,
    input  final_clk,
    input  tick,
    input  pending,
    input  running,
    input  count
  );

  modport slave (
    input  enable,
    input  div_in,
    input  mode_in,
    input  div_load,
    output final_clk,
    output tick,
    output pending,
    output running,
    output count
  );

endinterface

// File: rtl/prog_freq_divider.sv
// Programmable clock divider with square/pulse output and glitch-free divisor
// changes: new settings are captured immediately but only take effect on a wrap.
module prog_freq_divider #(
  parameter int WIDTH      = 17,
  parameter int RESET_DIV  = 100000,
  parameter int RESET_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  prog_freq_divider_if.slave   bus
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(RESET_DIV);
  localparam logic             RST_MODE = (RESET_MODE != 0);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (RST_DIV != '0) ? RUN : STOP;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             act_mode_q, act_mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;
  logic             apply;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      count_q     <= '0;
      act_div_q   <= RST_DIV;
      act_mode_q  <= RST_MODE;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      sq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      act_div_q   <= act_div_d;
      act_mode_q  <= act_mode_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    act_div_d   = act_div_q;
    act_mode_d  = act_mode_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    wrap        = 1'b0;
    apply       = 1'b0;

    case (state_q)
      RUN: begin
        wrap = bus.enable && (count_q == act_div_q - WIDTH'(1));
        if (bus.enable) begin
          count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
        apply = pending_q && wrap;
      end
      default: begin
        // Stopped: counter parked at zero, a pending request applies at once.
        count_d = '0;
        apply   = pending_q;
      end
    endcase

    tick_d = wrap;
    sq_d   = sq_q ^ wrap;

    // Application uses the previously captured request; a coincident load
    // below becomes the next pending request.
    if (apply) begin
      act_div_d  = pend_div_q;
      act_mode_d = pend_mode_q;
      pending_d  = 1'b0;
      state_d    = (pend_div_q != '0) ? RUN : STOP;
    end

    if (bus.div_load) begin
      pend_div_d  = bus.div_in;
      pend_mode_d = bus.mode_in;
      pending_d   = 1'b1;
    end
  end

  assign bus.final_clk = act_mode_q ? tick_q : sq_q;
  assign bus.tick      = tick_q;
  assign bus.pending   = pending_q;
  assign bus.running   = (state_q == RUN);
  assign bus.count     = count_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider with RESET_DIV=4, square mode at reset.
module tb_prog_freq_divider;

  localparam int W = 17;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  prog_freq_divider_if #(.WIDTH(W)) bus ();

  prog_freq_divider #(
    .WIDTH      (W),
    .RESET_DIV  (4),
    .RESET_MODE (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] d, input logic m);
    bus.div_in   = d;
    bus.mode_in  = m;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (bus.count !== 17'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.final_clk !== 1'b0) begin failures++; $display("FAIL reset_final_clk got=%b exp=0", bus.final_clk); end
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL reset_running got=%b exp=1", bus.running); end
    reset = 1'b1;
  endtask

  task automatic test_square();
    logic [W-1:0] exp_cnt;
    logic         exp_tick;
    logic         exp_fc;
    bus.enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_cnt  = W'(k % 4);
      exp_tick = (k % 4 == 0);
      exp_fc   = (k >= 4 && k < 8);
      checks++; if (bus.count !== exp_cnt) begin failures++; $display("FAIL sq_count edge=%0d got=%0d exp=%0d", k, bus.count, exp_cnt); end
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL sq_tick edge=%0d got=%b exp=%b", k, bus.tick, exp_tick); end
      checks++; if (bus.final_clk !== exp_fc) begin failures++; $display("FAIL sq_final_clk edge=%0d got=%b exp=%b", k, bus.final_clk, exp_fc); end
    end
  endtask

  task automatic test_load_div2();
    step();
    load(17'd2, 1'b0);
    checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL ld2_pending got=%b exp=1", bus.pending); end
    checks++; if (bus.count !== 17'd2) begin failures++; $display("FAIL ld2_count got=%0d exp=2", bus.count); end
    step();
    checks++; if (bus.count !== 17'd3) begin failures++; $display("FAIL ld2_old_period got=%0d exp=3", bus.count); end
    step();
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL ld2_applied_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL ld2_wrap_tick got=%b exp=1", bus.tick); end
    checks++; if (bus.final_clk !== 1'b1) begin failures++; $display("FAIL ld2_wrap_fc got=%b exp=1", bus.final_clk); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (bus.tick !== (k % 2 == 0)) begin failures++; $display("FAIL ld2_tick edge=%0d got=%b exp=%b", k, bus.tick, (k % 2 == 0)); end
    end
  endtask

  task automatic test_stop_pulse();
    load(17'd0, 1'b0);
    checks++; if (bus.count !== 17'd1) begin failures++; $display("FAIL stop_count got=%0d exp=1", bus.count); end
    step();
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL stop_last_tick got=%b exp=1", bus.tick); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL stop_running got=%b exp=0", bus.running); end
    step();
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL stop_hold_running got=%b exp=0", bus.running); end
    checks++; if (bus.final_clk !== 1'b0) begin failures++; $display("FAIL stop_hold_fc got=%b exp=0", bus.final_clk); end
    checks++; if (bus.count !== 17'd0) begin failures++; $display("FAIL stop_hold_count got=%0d exp=0", bus.count); end
    load(17'd3, 1'b1);
    checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL pulse_pending got=%b exp=1", bus.pending); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL pulse_still_stop got=%b exp=0", bus.running); end
    step();
    checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL pulse_run got=%b exp=1", bus.running); end
    checks++; if (bus.count !== 17'd0) begin failures++; $display("FAIL pulse_start_count got=%0d exp=0", bus.count); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL pulse_start_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL pulse_start_pending got=%b exp=0", bus.pending); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (bus.final_clk !== (k % 3 == 0)) begin failures++; $display("FAIL pulse_fc edge=%0d got=%b exp=%b", k, bus.final_clk, (k % 3 == 0)); end
    end
  endtask

  task automatic test_div1();
    load(17'd1, 1'b0);
    step();
    checks++; if (bus.count !== 17'd2) begin failures++; $display("FAIL div1_pre_count got=%0d exp=2", bus.count); end
    step();
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL div1_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.final_clk !== 1'b1) begin failures++; $display("FAIL div1_apply_fc got=%b exp=1", bus.final_clk); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL div1_tick edge=%0d got=%b exp=1", k, bus.tick); end
      checks++; if (bus.final_clk !== (k % 2 == 0)) begin failures++; $display("FAIL div1_fc edge=%0d got=%b exp=%b", k, bus.final_clk, (k % 2 == 0)); end
      checks++; if (bus.count !== 17'd0) begin failures++; $display("FAIL div1_count edge=%0d got=%0d exp=0", k, bus.count); end
    end
  endtask

  task automatic test_enable_hold();
    load(17'd4, 1'b0);
    checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL hold_pending got=%b exp=1", bus.pending); end
    step();
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL hold_applied got=%b exp=0", bus.pending); end
    step();
    step();
    checks++; if (bus.count !== 17'd2) begin failures++; $display("FAIL hold_pre_count got=%0d exp=2", bus.count); end
    bus.enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (bus.count !== 17'd2) begin failures++; $display("FAIL hold_count cyc=%0d got=%0d exp=2", k, bus.count); end
      checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL hold_tick cyc=%0d got=%b exp=0", k, bus.tick); end
      checks++; if (bus.final_clk !== 1'b1) begin failures++; $display("FAIL hold_fc cyc=%0d got=%b exp=1", k, bus.final_clk); end
    end
    bus.enable = 1'b1;
    step();
    checks++; if (bus.count !== 17'd3 || bus.tick !== 1'b0) begin failures++; $display("FAIL hold_resume1 count=%0d tick=%b exp count=3 tick=0", bus.count, bus.tick); end
    step();
    checks++; if (bus.count !== 17'd0 || bus.tick !== 1'b1 || bus.final_clk !== 1'b0) begin failures++; $display("FAIL hold_resume2 count=%0d tick=%b fc=%b exp 0/1/0", bus.count, bus.tick, bus.final_clk); end
  endtask

  task automatic test_reset_mid();
    step();
    load(17'd2, 1'b1);
    checks++; if (bus.count !== 17'd2 || bus.pending !== 1'b1) begin failures++; $display("FAIL rmid_pre count=%0d pending=%b exp 2/1", bus.count, bus.pending); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.count !== 17'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.tick !== 1'b0 || bus.final_clk !== 1'b0) begin failures++; $display("FAIL rmid_outs tick=%b fc=%b exp 0/0", bus.tick, bus.final_clk); end
    step();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (bus.count !== W'(k % 4)) begin failures++; $display("FAIL rmid_count_after edge=%0d got=%0d exp=%0d", k, bus.count, k % 4); end
      checks++; if (bus.tick !== (k == 4)) begin failures++; $display("FAIL rmid_tick edge=%0d got=%b exp=%b", k, bus.tick, (k == 4)); end
    end
  endtask

  task automatic test_back_to_back();
    load(17'd2, 1'b0);
    load(17'd3, 1'b0);
    step();
    checks++; if (bus.count !== 17'd3 || bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pre count=%0d pending=%b exp 3/1", bus.count, bus.pending); end
    step();
    checks++; if (bus.tick !== 1'b1 || bus.pending !== 1'b0) begin failures++; $display("FAIL b2b_apply tick=%b pending=%b exp 1/0", bus.tick, bus.pending); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (bus.tick !== (k == 3)) begin failures++; $display("FAIL b2b_div3_tick edge=%0d got=%b exp=%b", k, bus.tick, (k == 3)); end
    end
    load(17'd2, 1'b0);
    step();
    load(17'd4, 1'b0);
    checks++; if (bus.tick !== 1'b1 || bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_coincide tick=%b pending=%b exp 1/1", bus.tick, bus.pending); end
    step();
    checks++; if (bus.count !== 17'd1) begin failures++; $display("FAIL b2b_div2_count got=%0d exp=1", bus.count); end
    step();
    checks++; if (bus.tick !== 1'b1 || bus.pending !== 1'b0) begin failures++; $display("FAIL b2b_second_apply tick=%b pending=%b exp 1/0", bus.tick, bus.pending); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (bus.count !== W'(k % 4)) begin failures++; $display("FAIL b2b_div4_count edge=%0d got=%0d exp=%0d", k, bus.count, k % 4); end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.div_in   = '0;
    bus.mode_in  = 1'b0;
    bus.div_load = 1'b0;
    test_reset();
    test_square();
    test_load_div2();
    test_stop_pulse();
    test_div1();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
